// File: rtl/vga_noise_pkg.sv
// Shared constants for the noise renderer: palette modes, default parameter
// values, VGA 640x480 timing and the bundled sync/blank record.
package vga_noise_pkg;

   localparam logic [1:0] MODE_GRAY   = 2'd0;
   localparam logic [1:0] MODE_RAW    = 2'd1;
   localparam logic [1:0] MODE_FIRE   = 2'd2;
   localparam logic [1:0] MODE_INVERT = 2'd3;

   localparam int DEF_COLOR_BITS  = 2;
   localparam int DEF_SCALE_SHIFT = 2;
   localparam int DEF_T_WIDTH     = 20;
   localparam int DEF_FRAME_DIV   = 1;
   localparam int DEF_NOISE_LAT   = 1;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;

   typedef struct packed {
      logic hs;
      logic vs;
      logic av;
   } sync_t;

   localparam sync_t SYNC_RESET = '{hs: 1'b1, vs: 1'b1, av: 1'b0};

endpackage

// File: rtl/noise_palette.sv
// Combinational noise-to-colour mapping; the parent registers the result.
module noise_palette
   import vga_noise_pkg::*;
#(
   parameter int COLOR_BITS = DEF_COLOR_BITS
) (
   input  logic [7:0]              noise,
   input  logic [1:0]              mode,
   output logic [3*COLOR_BITS-1:0] rgb
);

   function automatic logic [7:0] sat_double(input logic [7:0] v);
      return v[7] ? 8'hFF : {v[6:0], 1'b0};
   endfunction

   function automatic logic [COLOR_BITS-1:0] ch(input logic [7:0] v);
      return v[7 -: COLOR_BITS];
   endfunction

   logic [COLOR_BITS-1:0] r, g, b;

   always_comb begin
      r   = '0;
      g   = '0;
      b   = '0;
      rgb = '0;
      case (mode)
         MODE_GRAY: begin
            r   = ch(noise);
            rgb = {r, r, r};
         end
         MODE_RAW: rgb = noise[7 -: 3*COLOR_BITS];
         MODE_FIRE: begin
            // Upper half of the noise range spills into green once red saturates.
            r   = ch(sat_double(noise));
            g   = noise[7] ? ch({noise[6:0], 1'b0}) : '0;
            rgb = {r, g, b};
         end
         MODE_INVERT: begin
            r   = ch(~noise);
            rgb = {r, r, r};
         end
      endcase
   end

endmodule

// File: rtl/perlin_noise_generator.sv
// Lattice hash noise: 8-bit value from (x, y, t), delivered LATENCY clocks
// after the inputs through a reset-to-zero delay line.
module perlin_noise_generator #(
   parameter int T_WIDTH = 20,
   parameter int LATENCY = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [9:0]         x,
   input  logic [9:0]         y,
   input  logic [T_WIDTH-1:0] t,
   output logic [7:0]         noise
);

   logic [15:0] mix;
   logic [7:0]  hash;

   assign mix  = {6'd0, x} ^ {5'd0, y, 1'b0};
   assign hash = 8'(mix * 16'd29) + 8'(32'(t) * 32'd7);

   generate
      if (LATENCY == 0) begin : g_comb
         assign noise = hash;
      end else begin : g_pipe
         logic [7:0] pipe_q [LATENCY];
         logic [7:0] pipe_d [LATENCY];

         always_comb begin
            pipe_d[0] = hash;
            for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
            end else begin
               pipe_q <= pipe_d;
            end
         end

         assign noise = pipe_q[LATENCY-1];
      end
   endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counter: pixel coordinates plus active-low syncs and the
// active-video flag, all decoded from the current counter values.
module VgaSyncGen
   import vga_noise_pkg::*;
#(
   parameter int H_VIS = H_VISIBLE,
   parameter int H_FP  = H_FRONT,
   parameter int H_SW  = H_SYNC,
   parameter int H_BP  = H_BACK,
   parameter int V_VIS = V_VISIBLE,
   parameter int V_FP  = V_FRONT,
   parameter int V_SW  = V_SYNC,
   parameter int V_BP  = V_BACK
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] x_px,
   output logic [9:0] y_px,
   output logic       hsync,
   output logic       vsync,
   output logic       activevideo
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SW + V_BP;

   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;

   always_comb begin
      h_d = h_q + 10'd1;
      v_d = v_q;
      if (h_q == 10'(H_TOTAL - 1)) begin
         h_d = '0;
         v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign x_px        = h_q;
   assign y_px        = v_q;
   assign hsync       = !((h_q >= 10'(H_VIS + H_FP)) && (h_q < 10'(H_VIS + H_FP + H_SW)));
   assign vsync       = !((v_q >= 10'(V_VIS + V_FP)) && (v_q < 10'(V_VIS + V_FP + V_SW)));
   assign activevideo = (h_q < 10'(H_VIS)) && (v_q < 10'(V_VIS));

endmodule

// File: rtl/vga_noise_renderer.sv
// Animated noise renderer: frame-ticked time counter with prescaler, speed,
// pause and single-step, palette mapping and latency-matched sync outputs.
module vga_noise_renderer
   import vga_noise_pkg::*;
#(
   parameter int COLOR_BITS  = DEF_COLOR_BITS,
   parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
   parameter int T_WIDTH     = DEF_T_WIDTH,
   parameter int FRAME_DIV   = DEF_FRAME_DIV,
   parameter int NOISE_LAT   = DEF_NOISE_LAT,
   parameter int H_VIS       = H_VISIBLE,
   parameter int H_FP        = H_FRONT,
   parameter int H_SW        = H_SYNC,
   parameter int H_BP        = H_BACK,
   parameter int V_VIS       = V_VISIBLE,
   parameter int V_FP        = V_FRONT,
   parameter int V_SW        = V_SYNC,
   parameter int V_BP        = V_BACK
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    pause,
   input  logic                    step,
   input  logic [3:0]              speed,
   input  logic [1:0]              mode,
   output logic                    hsync,
   output logic                    vsync,
   output logic [3*COLOR_BITS-1:0] out_rgb,
   output logic [T_WIDTH-1:0]      frame_t
);

   generate
      if (COLOR_BITS < 1 || COLOR_BITS > 2) begin : g_bad_color_bits
         $error("vga_noise_renderer: COLOR_BITS must be 1..2");
      end
      if (SCALE_SHIFT < 0 || SCALE_SHIFT > 4) begin : g_bad_scale_shift
         $error("vga_noise_renderer: SCALE_SHIFT must be 0..4");
      end
      if (FRAME_DIV < 1 || FRAME_DIV > 255) begin : g_bad_frame_div
         $error("vga_noise_renderer: FRAME_DIV must be 1..255");
      end
   endgenerate

   localparam logic [9:0] CELL_MASK = ~10'((1 << SCALE_SHIFT) - 1);
   localparam logic [7:0] PRESC_MAX = 8'(FRAME_DIV - 1);

   logic [9:0] x_px, y_px;
   logic       raw_hs, raw_vs, raw_av;
   logic [7:0] noise;
   logic [3*COLOR_BITS-1:0] pal_rgb;

   VgaSyncGen #(
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
   ) u_sync (
      .clk        (clk),
      .reset      (~rst_n),
      .x_px       (x_px),
      .y_px       (y_px),
      .hsync      (raw_hs),
      .vsync      (raw_vs),
      .activevideo(raw_av)
   );

   logic [T_WIDTH-1:0] frame_t_q, frame_t_d;

   perlin_noise_generator #(
      .T_WIDTH(T_WIDTH),
      .LATENCY(NOISE_LAT)
   ) u_noise (
      .clk  (clk),
      .rst_n(rst_n),
      .x    (x_px & CELL_MASK),
      .y    (y_px & CELL_MASK),
      .t    (frame_t_q),
      .noise(noise)
   );

   logic [9:0] prev_y_q, prev_y_d;
   logic [7:0] presc_q, presc_d;
   logic       step_pending_q, step_pending_d;
   logic [1:0] mode_sh_q, mode_sh_d;
   logic [3:0] speed_sh_q, speed_sh_d;
   logic       frame_tick, anim_tick, step_eff;

   always_comb begin
      prev_y_d       = y_px;
      frame_tick     = (y_px != prev_y_q) && (y_px == 10'd0);
      anim_tick      = frame_tick && (presc_q == PRESC_MAX);
      step_eff       = step_pending_q | (step & pause);
      step_pending_d = pause & step_eff;
      presc_d        = presc_q;
      mode_sh_d      = mode_sh_q;
      speed_sh_d     = speed_sh_q;
      frame_t_d      = frame_t_q;
      // Shadows follow every frame tick so palette/speed never change mid-frame.
      if (frame_tick) begin
         presc_d    = anim_tick ? 8'd0 : presc_q + 8'd1;
         mode_sh_d  = mode;
         speed_sh_d = speed;
      end
      if (anim_tick) begin
         step_pending_d = 1'b0;
         if (!pause)        frame_t_d = frame_t_q + T_WIDTH'(speed_sh_q);
         else if (step_eff) frame_t_d = frame_t_q + T_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_y_q       <= '0;
         presc_q        <= '0;
         step_pending_q <= 1'b0;
         mode_sh_q      <= MODE_GRAY;
         speed_sh_q     <= 4'd1;
         frame_t_q      <= '0;
      end else begin
         prev_y_q       <= prev_y_d;
         presc_q        <= presc_d;
         step_pending_q <= step_pending_d;
         mode_sh_q      <= mode_sh_d;
         speed_sh_q     <= speed_sh_d;
         frame_t_q      <= frame_t_d;
      end
   end

   noise_palette #(.COLOR_BITS(COLOR_BITS)) u_palette (
      .noise(noise),
      .mode (mode_sh_q),
      .rgb  (pal_rgb)
   );

   // Sync delay line: entry k carries the raster state k+1 clocks old.
   sync_t sync_q [NOISE_LAT+1];
   sync_t sync_d [NOISE_LAT+1];
   logic  av_lat;
   logic [3*COLOR_BITS-1:0] rgb_q, rgb_d;

   generate
      if (NOISE_LAT == 0) begin : g_av_raw
         assign av_lat = raw_av;
      end else begin : g_av_pipe
         assign av_lat = sync_q[NOISE_LAT-1].av;
      end
   endgenerate

   always_comb begin
      sync_d[0] = '{hs: raw_hs, vs: raw_vs, av: raw_av};
      for (int i = 1; i <= NOISE_LAT; i++) sync_d[i] = sync_q[i-1];
      rgb_d = av_lat ? pal_rgb : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= NOISE_LAT; i++) sync_q[i] <= SYNC_RESET;
         rgb_q <= '0;
      end else begin
         sync_q <= sync_d;
         rgb_q  <= rgb_d;
      end
   end

   assign hsync   = sync_q[NOISE_LAT].hs;
   assign vsync   = sync_q[NOISE_LAT].vs;
   assign out_rgb = rgb_q;
   assign frame_t = frame_t_q;

endmodule
